// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data memory arbiter
package dmem_pkg;

    localparam int DMEM_DEPTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Master indices; the round-robin pointer holds one of these.
    localparam logic M_CORE = 1'b0;
    localparam logic M_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational two-way winner select
//
// Ports:
//   req0, req1   request from master 0 (core) / master 1 (debug)
//   state        arbiter FSM state; a LOCKn state admits only master n
//   ptr          master that wins a contended cycle in IDLE
//   gnt0, gnt1   one-hot (or zero) winner
module dmem_arb_pick
    import dmem_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  arb_state_t state,
    input  logic       ptr,
    output logic       gnt0,
    output logic       gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            LOCK0: gnt0 = req0;
            LOCK1: gnt1 = req1;
            default: begin
                if (req0 && req1) begin
                    if (ptr == M_CORE) gnt0 = 1'b1;
                    else               gnt1 = 1'b1;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter/sequencer in front of single-port data_mem
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mN_req/we/lock/addr/wdata    master N request (N = 0 core, 1 debug)
//   mN_gnt                       combinational grant, access happens this cycle
//   mN_rvalid/rdata/err          registered response, one cycle after grant
//   mem_we/addr/wd, mem_rd       data_mem port (combinational read)
//
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration on contended
// cycles; without it master 0 always wins and no pointer register exists.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m0_err,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          m1_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd
);

    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    arb_state_t  state_q, state_d;
    logic        ptr;
    logic        pick0, pick1;
    logic        m0_ok, m1_ok;
    logic        rvalid0_q, rvalid1_q, err0_q, err1_q;
    logic [31:0] rdata0_q, rdata1_q;

    assign m0_ok = (m0_addr < DEPTH_W);
    assign m1_ok = (m1_addr < DEPTH_W);

`ifdef DMEM_ARB_RR_EN
    // Only contended IDLE cycles move the pointer; a lone requester never does.
    always_ff @(posedge clk) begin
        if (rst)                                   ptr <= M_CORE;
        else if (state_q == IDLE && m0_req && m1_req) ptr <= ~ptr;
    end
`else
    assign ptr = M_CORE;
`endif

    dmem_arb_pick u_pick (
        .req0  (m0_req),
        .req1  (m1_req),
        .state (state_q),
        .ptr   (ptr),
        .gnt0  (pick0),
        .gnt1  (pick1)
    );

    // Reset overrides any request so nothing reaches memory in a reset cycle.
    assign m0_gnt = pick0 & ~rst;
    assign m1_gnt = pick1 & ~rst;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (m0_gnt) begin
            mem_we   = m0_we & m0_ok;
            mem_addr = m0_addr;
            mem_wd   = m0_wdata;
        end else if (m1_gnt) begin
            mem_we   = m1_we & m1_ok;
            mem_addr = m1_addr;
            mem_wd   = m1_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_gnt && m0_lock)      state_d = LOCK0;
                else if (m1_gnt && m1_lock) state_d = LOCK1;
            end
            LOCK0: begin
                if ((m0_gnt && !m0_lock) || (!m0_req && !m0_lock)) state_d = IDLE;
            end
            LOCK1: begin
                if ((m1_gnt && !m1_lock) || (!m1_req && !m1_lock)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            rvalid0_q <= m0_gnt & ~m0_we;
            rvalid1_q <= m1_gnt & ~m1_we;
            err0_q    <= m0_gnt & ~m0_ok;
            err1_q    <= m1_gnt & ~m1_ok;
            // rdata only moves on a read response; out-of-range reads return zero.
            if (m0_gnt && !m0_we) rdata0_q <= m0_ok ? mem_rd : 32'h0;
            if (m1_gnt && !m1_we) rdata1_q <= m1_ok ? mem_rd : 32'h0;
        end
    end

    // A reset cycle cancels a response already registered for that cycle.
    assign m0_rvalid = rvalid0_q & ~rst;
    assign m1_rvalid = rvalid1_q & ~rst;
    assign m0_err    = err0_q & ~rst;
    assign m1_err    = err1_q & ~rst;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    logic [31:0] mem [0:63];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        exp0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // data_mem: combinational read, write on rising edge
    always @(posedge clk) if (mem_we) mem[mem_addr[5:0]] <= mem_wd;
    assign mem_rd = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start a new cycle: inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic lock, input logic [31:0] a, input logic [31:0] d);
        m0_req = req; m0_we = we; m0_lock = lock; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drive1(input logic req, input logic we, input logic lock, input logic [31:0] a, input logic [31:0] d);
        m1_req = req; m1_we = we; m1_lock = lock; m1_addr = a; m1_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst = 1'b1;
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("rst_gnt0", {31'b0, m0_gnt}, 0);
        check_eq("rst_gnt1", {31'b0, m1_gnt}, 0);
        check_eq("rst_rvalid0", {31'b0, m0_rvalid}, 0);
        check_eq("rst_err0", {31'b0, m0_err}, 0);
        check_eq("rst_mem_we", {31'b0, mem_we}, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wd", mem_wd, 0);
        check_eq("rst_rdata0", m0_rdata, 0);
        check_eq("rst_rdata1", m1_rdata, 0);
        check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));

        // write then read back addr 5
        cyc(); drive0(1, 1, 0, 5, 32'hDEADBEEF); #1;
        check_eq("wr5_gnt0", {31'b0, m0_gnt}, 1);
        check_eq("wr5_mem_we", {31'b0, mem_we}, 1);
        check_eq("wr5_mem_addr", mem_addr, 5);
        check_eq("wr5_mem_wd", mem_wd, 32'hDEADBEEF);
        cyc(); drive0(1, 0, 0, 5, 0); #1;
        check_eq("rd5_gnt0", {31'b0, m0_gnt}, 1);
        check_eq("rd5_we0", {31'b0, mem_we}, 0);
        check_eq("wr5_no_rvalid", {31'b0, m0_rvalid}, 0);
        cyc(); drive0(0, 0, 0, 0, 0); #1;
        check_eq("rd5_rvalid0", {31'b0, m0_rvalid}, 1);
        check_eq("rd5_rdata0", m0_rdata, 32'hDEADBEEF);
        check_eq("rd5_rvalid1", {31'b0, m1_rvalid}, 0);
        check_eq("rd5_rdata1", m1_rdata, 0);
        check_eq("rd5_gnt1", {31'b0, m1_gnt}, 0);
        cyc(); #1;
        check_eq("rd5_rvalid_drop", {31'b0, m0_rvalid}, 0);
        check_eq("rd5_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // contention: both read for 4 cycles
        for (int i = 0; i < 4; i++) begin
            cyc(); drive0(1, 0, 0, 1, 0); drive1(1, 0, 0, 2, 0); #1;
`ifdef DMEM_ARB_RR_EN
            exp0 = (i % 2 == 0);
`else
            exp0 = 1'b1;
`endif
            check_eq($sformatf("cont%0d_gnt0", i), {31'b0, m0_gnt}, {31'b0, exp0});
            check_eq($sformatf("cont%0d_gnt1", i), {31'b0, m1_gnt}, {31'b0, ~exp0});
        end
        cyc(); drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
        cyc();

        // lock by master 1 blocks master 0
        cyc(); drive1(1, 1, 0, 10, 32'h12345678); #1;
        check_eq("m1wr10_gnt1", {31'b0, m1_gnt}, 1);
        check_eq("m1wr10_addr", mem_addr, 10);
        cyc(); drive1(1, 0, 1, 10, 0); #1;
        check_eq("m1lk_gnt1", {31'b0, m1_gnt}, 1);
        cyc(); drive1(1, 0, 1, 10, 0); drive0(1, 0, 0, 10, 0); #1;
        check_eq("lk_a_gnt0", {31'b0, m0_gnt}, 0);
        check_eq("lk_a_gnt1", {31'b0, m1_gnt}, 1);
        check_eq("lk_a_rvalid1", {31'b0, m1_rvalid}, 1);
        check_eq("lk_a_rdata1", m1_rdata, 32'h12345678);
        cyc(); drive1(1, 1, 0, 10, 32'hA5A5A5A5); #1;
        check_eq("lk_b_gnt0", {31'b0, m0_gnt}, 0);
        check_eq("lk_b_gnt1", {31'b0, m1_gnt}, 1);
        check_eq("lk_b_mem_we", {31'b0, mem_we}, 1);
        check_eq("lk_b_rvalid0", {31'b0, m0_rvalid}, 0);
        cyc(); drive1(0, 0, 0, 0, 0); #1;
        check_eq("lk_c_gnt0", {31'b0, m0_gnt}, 1);
        check_eq("lk_c_rvalid1", {31'b0, m1_rvalid}, 0);
        cyc(); drive0(0, 0, 0, 0, 0); #1;
        check_eq("lk_c_rdata0", m0_rdata, 32'hA5A5A5A5);
        check_eq("lk_c_rvalid0", {31'b0, m0_rvalid}, 1);
        check_eq("lk_c_rdata1_hold", m1_rdata, 32'h12345678);

        // address range boundary
        cyc(); drive0(1, 1, 0, 63, 32'h63); #1;
        check_eq("wr63_mem_we", {31'b0, mem_we}, 1);
        cyc(); drive0(1, 1, 0, 64, 32'h1); #1;
        check_eq("wr64_gnt0", {31'b0, m0_gnt}, 1);
        check_eq("wr64_mem_we", {31'b0, mem_we}, 0);
        check_eq("wr63_err", {31'b0, m0_err}, 0);
        cyc(); drive0(1, 0, 0, 64, 0); #1;
        check_eq("wr64_err", {31'b0, m0_err}, 1);
        check_eq("wr64_rvalid", {31'b0, m0_rvalid}, 0);
        cyc(); drive0(0, 0, 0, 0, 0); #1;
        check_eq("rd64_rvalid", {31'b0, m0_rvalid}, 1);
        check_eq("rd64_err", {31'b0, m0_err}, 1);
        check_eq("rd64_rdata", m0_rdata, 0);
        cyc(); #1;
        check_eq("rd64_err_drop", {31'b0, m0_err}, 0);
        check_eq("mem63", mem[63], 32'h63);

        // reset during a locked read response
        cyc(); drive0(1, 0, 1, 5, 0); #1;
        check_eq("rstlk_gnt0", {31'b0, m0_gnt}, 1);
        cyc(); rst = 1'b1; drive0(1, 1, 0, 7, 32'h77); #1;
        check_eq("rstcyc_rvalid0", {31'b0, m0_rvalid}, 0);
        check_eq("rstcyc_gnt0", {31'b0, m0_gnt}, 0);
        check_eq("rstcyc_mem_we", {31'b0, mem_we}, 0);
        cyc(); rst = 1'b0; drive0(0, 0, 0, 0, 0); #1;
        check_eq("postrst_rvalid0", {31'b0, m0_rvalid}, 0);
        check_eq("postrst_rdata0", m0_rdata, 0);
        check_eq("postrst_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("postrst_mem7", mem[7], 0);
        cyc(); drive1(1, 0, 0, 5, 0); #1;
        check_eq("postrst_gnt1", {31'b0, m1_gnt}, 1);
        cyc(); drive1(0, 0, 0, 0, 0);
        cyc();

        // lock released by dropping req and lock, pending m1 then served
        cyc(); drive0(1, 0, 1, 3, 0); drive1(1, 0, 0, 2, 0); #1;
        check_eq("rel_gnt0", {31'b0, m0_gnt}, 1);
        check_eq("rel_gnt1", {31'b0, m1_gnt}, 0);
        cyc(); drive0(0, 0, 0, 0, 0); #1;
        check_eq("rel_lock_gnt1", {31'b0, m1_gnt}, 0);
        check_eq("rel_rvalid0", {31'b0, m0_rvalid}, 1);
        cyc(); #1;
        check_eq("rel_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("rel_idle_gnt1", {31'b0, m1_gnt}, 1);
        cyc(); drive1(0, 0, 0, 0, 0); #1;
        check_eq("rel_rvalid1", {31'b0, m1_rvalid}, 1);
        check_eq("rel_rvalid0_off", {31'b0, m0_rvalid}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
